// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches under a credit limit,
// buffers returned words with their PC and streams them to the decoder.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;

  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [31:0]       fifo_data_q [DEPTH];

  logic              fire;
  logic              push;
  logic              pop;
  logic [CW:0]       inflight;
  logic [ADDR_W-1:0] redirect_aligned;

  // Credits cover both in-flight requests and buffered words, so a push never overflows.
  assign inflight         = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid   = rst_n && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr    = fetch_pc_q;
  assign fire             = imem_req_valid && imem_req_ready;
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;

  assign push = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Entry storage needs no reset: outputs are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule
